// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit, the instruction BRAM,
// the branch redirect source and the decode stage.
// master: the fetch unit side; slave: the environment side.
interface instr_fetch_unit_if #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  branch_valid;
    logic [ADDR_BITS-1:0]  branch_target;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_BITS-1:0]  instr_pc;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        input  branch_valid, branch_target,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        output branch_valid, branch_target,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads to a BRAM with a 1-cycle
// registered read latency, buffers returned words in a small prefetch
// queue and presents {pc, instruction} to decode over valid/ready.
// A branch redirect flushes the queue and drops any read in flight.
// Optional build macro FETCH_STATS_EN adds saturating fetch/flush counters.
// QDEPTH must be 2 or 4 (power of two so queue pointers wrap naturally).
module instr_fetch_unit #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PC   = 0,
    parameter int QDEPTH     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_fetch_unit_if.master    bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [15:0]           flush_count
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [ADDR_BITS-1:0] RESET_ADDR = ADDR_BITS'(RESET_PC);

    logic [ADDR_BITS-1:0]  pc;
    logic [ADDR_BITS-1:0]  pending_pc;
    logic [ADDR_BITS-1:0]  last_addr;
    logic [ADDR_BITS-1:0]  issue_addr;
    logic                  pending;
    logic [DATA_WIDTH-1:0] q_data [QDEPTH];
    logic [ADDR_BITS-1:0]  q_pc   [QDEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  head_taken;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CW:0]           occupancy;

    // Issue decision: a redirect always issues; otherwise only while the
    // words already owed (queued + in flight - leaving) leave a free slot.
    always_comb begin
        head_taken = bus.instr_valid && bus.instr_ready;
        pop        = head_taken && !bus.branch_valid;
        push       = pending && !bus.branch_valid;
        occupancy  = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(head_taken);
        issue      = !reset && (bus.branch_valid || (int'(occupancy) < QDEPTH));
        issue_addr = bus.branch_valid ? bus.branch_target : pc;
    end

    assign bus.mem_en      = issue;
    assign bus.mem_addr    = issue ? issue_addr : last_addr;
    assign bus.mem_we      = 1'b0;
    assign bus.mem_wdata   = '0;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = q_data[rd_ptr];
    assign bus.instr_pc    = q_pc[rd_ptr];

    // Fetch pointer, in-flight read tracking and queue bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_ADDR;
            pending    <= 1'b0;
            pending_pc <= '0;
            last_addr  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (issue) begin
                pc        <= issue_addr + 1'b1;
                last_addr <= issue_addr;
            end
            pending    <= issue;
            pending_pc <= issue_addr;
            if (bus.branch_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_data[wr_ptr] <= bus.mem_rdata;
            q_pc[wr_ptr]   <= pending_pc;
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating counts of delivered instructions and redirects.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (pop && (fetch_count != '1))
                fetch_count <= fetch_count + 1'b1;
            if (bus.branch_valid && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed vector table, hand-written
// branch/reset sequences and a randomized run against a stream model.
module tb_instr_fetch_unit;
    localparam int AB = 9;
    localparam int DW = 32;
    localparam int QD = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    instr_fetch_unit_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) bus();

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    instr_fetch_unit #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .RESET_PC(0), .QDEPTH(QD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    int   errors = 0;
    int   checks = 0;
    logic scramble = 1'b0;

    function automatic logic [DW-1:0] word(input logic [AB-1:0] a, input logic scr);
        if (scr) return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        return 32'(a);
    endfunction

    // BRAM with registered read
    always @(posedge clock) begin
        if (bus.mem_en) bus.mem_rdata <= word(bus.mem_addr, scramble);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic br, input logic [AB-1:0] tgt);
        @(posedge clock);
        #1;
        reset             = rst;
        bus.instr_ready   = rdy;
        bus.branch_valid  = br;
        bus.branch_target = tgt;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_head(input string name, input logic [AB-1:0] pc);
        chk({name, "_valid"}, 64'(bus.instr_valid), 64'd1);
        chk({name, "_pc"},    64'(bus.instr_pc),    64'(pc));
        chk({name, "_data"},  64'(bus.instr_data),  64'(word(pc, scramble)));
    endtask

    typedef struct {
        logic          rdy;
        logic          exp_en;
        logic [AB-1:0] exp_addr;
        logic          exp_valid;
        logic [AB-1:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic en, input int a, input logic v, input int p);
        vec_t t;
        t.rdy = r; t.exp_en = en; t.exp_addr = AB'(a); t.exp_valid = v; t.exp_pc = AB'(p);
        return t;
    endfunction

    vec_t tbl[17];

    // random-phase model state
    logic [AB-1:0] exp_pc;
    logic [AB-1:0] hold_pc;
    logic [DW-1:0] hold_data;
    logic          prev_hold;
    logic          prev_pop;
    int            age;
    int            outst;
    logic          rdy_r;
    logic          br_r;
    logic [AB-1:0] tgt_r;
    logic          pop_r;
    logic          found;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;

        // Streaming from reset, then a 6-cycle stall with head pc 5
        for (int c = 0; c < 7; c++) tbl[c] = mk(1'b1, 1'b1, c, c >= 2, c - 2);
        for (int c = 7; c < 13; c++) tbl[c] = mk(1'b0, 1'b0, 6, 1'b1, 5);
        tbl[13] = mk(1'b1, 1'b1, 7,  1'b1, 5);
        tbl[14] = mk(1'b1, 1'b1, 8,  1'b1, 6);
        tbl[15] = mk(1'b1, 1'b1, 9,  1'b1, 7);
        tbl[16] = mk(1'b1, 1'b1, 10, 1'b1, 8);

        do_reset();
        for (int c = 0; c < 17; c++) begin
            step(1'b0, tbl[c].rdy, 1'b0, '0);
            chk($sformatf("tbl%0d_mem_en", c),   64'(bus.mem_en),      64'(tbl[c].exp_en));
            chk($sformatf("tbl%0d_mem_addr", c), 64'(bus.mem_addr),    64'(tbl[c].exp_addr));
            chk($sformatf("tbl%0d_valid", c),    64'(bus.instr_valid), 64'(tbl[c].exp_valid));
            if (tbl[c].exp_valid) begin
                chk($sformatf("tbl%0d_pc", c),   64'(bus.instr_pc),   64'(tbl[c].exp_pc));
                chk($sformatf("tbl%0d_data", c), 64'(bus.instr_data), 64'(word(tbl[c].exp_pc, 1'b0)));
            end
            if (c == 0) begin
                chk("mem_we_zero",    64'(bus.mem_we),    64'd0);
                chk("mem_wdata_zero", 64'(bus.mem_wdata), 64'd0);
            end
        end

        // Queue full with 8,9 then branch to 0x40
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            if (bus.instr_valid && bus.instr_pc == 7) found = 1'b1;
        end
        chk("full_reach_pc7", 64'(found), 64'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk_head("full_stall0", 8);
        step(1'b0, 1'b0, 1'b0, '0);
        chk_head("full_stall1", 8);
        chk("full_no_issue", 64'(bus.mem_en), 64'd0);
        step(1'b0, 1'b1, 1'b1, 9'h040);
        chk("full_br_en",   64'(bus.mem_en),   64'd1);
        chk("full_br_addr", 64'(bus.mem_addr), 64'h040);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("full_bubble", 64'(bus.instr_valid), 64'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("full_target", 9'h040);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("full_target1", 9'h041);

        // Branch with pending read of pc 3 and simultaneous pop of pc 2
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 9'h020);
        chk_head("pend_br_head", 2);
        chk("pend_br_addr", 64'(bus.mem_addr), 64'h020);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("pend_bubble", 64'(bus.instr_valid), 64'd0);
        chk("pend_next_addr", 64'(bus.mem_addr), 64'h021);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("pend_target", 9'h020);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("pend_target1", 9'h021);

        // Wrap-around: branch to 510
        step(1'b0, 1'b1, 1'b1, 9'd510);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("wrap_bubble", 64'(bus.instr_valid), 64'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("wrap_510", 9'd510);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("wrap_511", 9'd511);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("wrap_0", 9'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("wrap_1", 9'd1);

        // One-cycle reset mid-stream
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_pc",    64'(bus.instr_pc),    64'd0);
        chk("rst_data",  64'(bus.instr_data),  64'd0);
        chk("rst_en",    64'(bus.mem_en),      64'd1);
        chk("rst_addr",  64'(bus.mem_addr),    64'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("rst_valid1", 64'(bus.instr_valid), 64'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("rst_first", 0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk_head("rst_second", 1);

`ifdef FETCH_STATS_EN
        do_reset();
        for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 9'd5);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 9'd9);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("stats_fetch", 64'(fetch_count), 64'd10);
        chk("stats_flush", 64'(flush_count), 64'd2);
`endif

        // Randomized run against the delivered-stream model
        scramble = 1'b1;
        do_reset();
        exp_pc    = '0;
        age       = 0;
        outst     = 0;
        prev_hold = 1'b0;
        prev_pop  = 1'b0;
        hold_pc   = '0;
        hold_data = '0;
        for (int i = 0; i < 600; i++) begin
            rdy_r = ($urandom_range(0, 9) < 7);
            br_r  = (i > 0) && ($urandom_range(0, 11) == 0);
            tgt_r = AB'($urandom);
            step(1'b0, rdy_r, br_r, tgt_r);

            if (age == 1) chk("rnd_bubble_after_branch", 64'(bus.instr_valid), 64'd0);
            if (age == 2) chk("rnd_valid_2_after_issue", 64'(bus.instr_valid), 64'd1);
            if (prev_pop) chk("rnd_no_bubble", 64'(bus.instr_valid), 64'd1);
            if (prev_hold) begin
                chk("rnd_hold_valid", 64'(bus.instr_valid), 64'd1);
                chk("rnd_hold_pc",    64'(bus.instr_pc),    64'(hold_pc));
                chk("rnd_hold_data",  64'(bus.instr_data),  64'(hold_data));
            end
            if (bus.instr_valid) begin
                chk("rnd_pc",   64'(bus.instr_pc),   64'(exp_pc));
                chk("rnd_data", 64'(bus.instr_data), 64'(word(bus.instr_pc, 1'b1)));
            end
            if (br_r) begin
                chk("rnd_br_en",   64'(bus.mem_en),   64'd1);
                chk("rnd_br_addr", 64'(bus.mem_addr), 64'(tgt_r));
            end

            pop_r     = bus.instr_valid && rdy_r && !br_r;
            prev_pop  = pop_r;
            prev_hold = bus.instr_valid && !rdy_r && !br_r;
            hold_pc   = bus.instr_pc;
            hold_data = bus.instr_data;
            if (br_r) begin
                exp_pc = tgt_r;
                outst  = 1;
                age    = 1;
            end else begin
                if (pop_r) exp_pc = exp_pc + 1'b1;
                outst = outst + int'(bus.mem_en) - int'(pop_r);
                age   = age + 1;
            end
            if (outst > QD || outst < 0)
                chk("rnd_no_overflow", 64'(outst), 64'(QD));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
